digit_canvas: RTL and testbench

28x28 binary drawing canvas that is the responder end of the classifier's pixel read interface.
- The classifier drives read_addr; this block returns read_data for that pixel.
- The user edits the image by moving a cursor with move pulses, using pen_down/erase levels and a clear request.
- A second read port (disp_addr/disp_data) serves the display scan-out.

---
 rtl/digit_canvas_pkg.sv | 26 ++
 rtl/digit_canvas_cursor_axis.sv | 35 +++
 rtl/digit_canvas.sv | 122 ++++++++++++
 tb/tb_digit_canvas.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/digit_canvas_pkg.sv
// Shared definitions for the 28x28 digit canvas and its classifier.
// The classifier sizes its input vector from PIXEL_COUNT, so both ends
// agree on the pixel store geometry through this package.
package digit_canvas_pkg;

  localparam int IMG_W       = 28;
  localparam int IMG_H       = 28;
  localparam int PIXEL_COUNT = IMG_W * IMG_H;
  localparam int ADDR_WIDTH  = 10;
  localparam int COORD_WIDTH = 5;
  localparam int CUR_INIT_X  = 14;
  localparam int CUR_INIT_Y  = 14;

  // FSM state encodings
  localparam logic [0:0] ST_DRAW  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Linear pixel index for a cursor position: y*IMG_W + x
  function automatic logic [ADDR_WIDTH-1:0] pixel_index(
    input logic [COORD_WIDTH-1:0] x,
    input logic [COORD_WIDTH-1:0] y
  );
    return ADDR_WIDTH'(y) * ADDR_WIDTH'(IMG_W) + ADDR_WIDTH'(x);
  endfunction

endpackage

// File: rtl/digit_canvas_cursor_axis.sv
// One cursor axis: a wrap-around counter over 0..MODULUS-1.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (pos <= INIT)
//   en        - update allowed this cycle
//   inc, dec  - one-cycle step pulses; both together cancel out
//   pos       - registered position
module canvas_cursor_axis
  import digit_canvas_pkg::*;
#(
  parameter int MODULUS = 28,
  parameter int INIT    = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   inc,
  input  logic                   dec,
  output logic [COORD_WIDTH-1:0] pos
);

  localparam logic [COORD_WIDTH-1:0] POS_MAX = COORD_WIDTH'(MODULUS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= COORD_WIDTH'(INIT);
    end else if (en && (inc ^ dec)) begin
      if (inc) begin
        pos <= (pos == POS_MAX) ? '0 : pos + 1'b1;
      end else begin
        pos <= (pos == '0) ? POS_MAX : pos - 1'b1;
      end
    end
  end

endmodule

// File: rtl/digit_canvas.sv
// 28x28 binary drawing canvas. Serves the classifier read port and a display
// scan-out port combinationally, and is edited by a cursor with pen/erase
// levels. A clear request sweeps every pixel to 0, one per cycle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// DRAW   | normal editing: cursor moves, pen/erase paint at the cursor
// CLEAR  | sweep canvas[clear_ptr] <= 0, all user inputs ignored
//
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   move_up/down/left/right          - one-cycle cursor step pulses
//   pen_down, erase                  - paint level inputs (erase wins)
//   clear_req                        - start a full-canvas clear sweep
//   read_addr/read_data              - classifier pixel read (zero latency)
//   disp_addr/disp_data              - display pixel read (zero latency)
//   cursor_x, cursor_y               - registered cursor position
//   busy                             - registered, high during the sweep
module digit_canvas
  import digit_canvas_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   move_up,
  input  logic                   move_down,
  input  logic                   move_left,
  input  logic                   move_right,
  input  logic                   pen_down,
  input  logic                   erase,
  input  logic                   clear_req,
  input  logic [ADDR_WIDTH-1:0]  read_addr,
  output logic                   read_data,
  input  logic [ADDR_WIDTH-1:0]  disp_addr,
  output logic                   disp_data,
  output logic [COORD_WIDTH-1:0] cursor_x,
  output logic [COORD_WIDTH-1:0] cursor_y,
  output logic                   busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIXEL = ADDR_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] PIX_LIMIT  = ADDR_WIDTH'(PIXEL_COUNT);

  logic [PIXEL_COUNT-1:0] canvas;
  logic [0:0]             state;
  logic [ADDR_WIDTH-1:0]  clear_ptr;
  logic                   drawing;

  logic                   wr_en;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic                   wr_val;

  assign drawing = (state == ST_DRAW);
  assign busy    = (state == ST_CLEAR);

  // Read ports: no write-through, so a write shows up the cycle after.
  assign read_data = (read_addr < PIX_LIMIT) ? canvas[read_addr] : 1'b0;
  assign disp_data = (disp_addr < PIX_LIMIT) ? canvas[disp_addr] : 1'b0;

  canvas_cursor_axis #(.MODULUS(IMG_W), .INIT(CUR_INIT_X)) u_axis_x (
    .clk (clk),
    .rst (rst),
    .en  (drawing),
    .inc (move_right),
    .dec (move_left),
    .pos (cursor_x)
  );

  canvas_cursor_axis #(.MODULUS(IMG_H), .INIT(CUR_INIT_Y)) u_axis_y (
    .clk (clk),
    .rst (rst),
    .en  (drawing),
    .inc (move_down),
    .dec (move_up),
    .pos (cursor_y)
  );

  // Single write port shared by paint and clear. Paint uses the cursor as
  // registered, i.e. the position before any move applied this cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_val  = 1'b0;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clear_ptr;
      wr_val  = 1'b0;
    end else if (erase || pen_down) begin
      wr_en   = 1'b1;
      wr_addr = pixel_index(cursor_x, cursor_y);
      wr_val  = ~erase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      canvas    <= '0;
      state     <= ST_DRAW;
      clear_ptr <= '0;
    end else begin
      if (wr_en) begin
        canvas[wr_addr] <= wr_val;
      end
      case (state)
        ST_DRAW: begin
          if (clear_req) begin
            state     <= ST_CLEAR;
            clear_ptr <= '0;
          end
        end
        default: begin
          if (clear_ptr == LAST_PIXEL) begin
            state     <= ST_DRAW;
            clear_ptr <= '0;
          end else begin
            clear_ptr <= clear_ptr + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_canvas.sv
module tb_digit_canvas;
  import digit_canvas_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       move_up, move_down, move_left, move_right;
  logic       pen_down, erase, clear_req;
  logic [9:0] read_addr, disp_addr;
  logic       read_data, disp_data;
  logic [4:0] cursor_x, cursor_y;
  logic       busy;

  digit_canvas dut (
    .clk        (clk),
    .rst        (rst),
    .move_up    (move_up),
    .move_down  (move_down),
    .move_left  (move_left),
    .move_right (move_right),
    .pen_down   (pen_down),
    .erase      (erase),
    .clear_req  (clear_req),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: image as a plain bit array, cursor as integers,
  // clear sweep as a count of pixels already wiped.
  bit m_img [784];
  int m_x, m_y;
  bit m_busy;
  int m_wiped;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_pix(input int a);
    return (a < 784) ? int'(m_img[a]) : 0;
  endfunction

  function automatic void model_edge(input bit u, d, l, r, pen, er, clr, rs);
    if (rs) begin
      foreach (m_img[i]) m_img[i] = 1'b0;
      m_x = 14; m_y = 14; m_busy = 0; m_wiped = 0;
    end else if (m_busy) begin
      m_img[m_wiped] = 1'b0;
      m_wiped++;
      if (m_wiped == 784) begin
        m_busy = 0;
        m_wiped = 0;
      end
    end else begin
      if (er) m_img[m_y * 28 + m_x] = 1'b0;
      else if (pen) m_img[m_y * 28 + m_x] = 1'b1;
      m_x = (m_x + int'(r) - int'(l) + 28) % 28;
      m_y = (m_y + int'(d) - int'(u) + 28) % 28;
      if (clr) begin
        m_busy = 1;
        m_wiped = 0;
      end
    end
  endfunction

  // One clock with the given inputs, then check outputs and a random pixel.
  task automatic step(input bit u, d, l, r, pen, er, clr, rs);
    move_up = u; move_down = d; move_left = l; move_right = r;
    pen_down = pen; erase = er; clear_req = clr; rst = rs;
    @(posedge clk);
    model_edge(u, d, l, r, pen, er, clr, rs);
    #1;
    move_up = 0; move_down = 0; move_left = 0; move_right = 0;
    pen_down = 0; erase = 0; clear_req = 0; rst = 0;
    read_addr = 10'($urandom_range(0, 1023));
    disp_addr = 10'($urandom_range(0, 790));
    #1;
    chk("cursor_x", int'(cursor_x), m_x);
    chk("cursor_y", int'(cursor_y), m_y);
    chk("busy", int'(busy), int'(m_busy));
    chk("read_rand", int'(read_data), m_pix(int'(read_addr)));
    chk("disp_rand", int'(disp_data), m_pix(int'(disp_addr)));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto_xy(input int x, input int y);
    for (int k = 0; k < 64 && m_x != x; k++) step(0, 0, m_x > x, m_x < x, 0, 0, 0, 0);
    for (int k = 0; k < 64 && m_y != y; k++) step(m_y > y, m_y < y, 0, 0, 0, 0, 0, 0);
    chk("goto_x", int'(cursor_x), x);
    chk("goto_y", int'(cursor_y), y);
  endtask

  task automatic sweep_all(input string tag);
    for (int a = 0; a < 784; a++) begin
      read_addr = 10'(a);
      disp_addr = 10'(783 - a);
      #1;
      chk({tag, "_read"}, int'(read_data), m_pix(a));
      chk({tag, "_disp"}, int'(disp_data), m_pix(783 - a));
    end
  endtask

  task automatic rand_step(input int clr_pct);
    step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
         $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0,
         $urandom_range(0, 99) < clr_pct, 0);
  endtask

  task automatic probe(input string tag, input int a, input int exp);
    read_addr = 10'(a);
    disp_addr = 10'(a);
    #1;
    chk({tag, "_read"}, int'(read_data), exp);
    chk({tag, "_disp"}, int'(disp_data), exp);
  endtask

  initial begin
    int busy_cnt;
    {move_up, move_down, move_left, move_right, pen_down, erase, clear_req} = '0;
    rst = 1'b1;
    read_addr = '0;
    disp_addr = '0;
    #2;

    // Reset state
    step(0, 0, 0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_x", int'(cursor_x), 14);
    chk("rst_y", int'(cursor_y), 14);
    chk("rst_busy", int'(busy), 0);
    sweep_all("rst");
    probe("oob800", 800, 0);
    probe("oob1023", 1023, 0);

    // Pen at (14,14) -> pixel 406
    probe("pre406", 406, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    probe("pen406", 406, 1);

    // Diagonal wrap from (27,0)
    goto_xy(27, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    chk("wrap_x", int'(cursor_x), 0);
    chk("wrap_y", int'(cursor_y), 27);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    chk("lr_cancel_x", int'(cursor_x), 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("ud_cancel_y", int'(cursor_y), 27);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    chk("wrap_left", int'(cursor_x), 27);

    // Paint uses pre-move position
    goto_xy(5, 5);
    step(0, 0, 0, 1, 1, 0, 0, 0);
    probe("pix145", 145, 1);
    probe("pix146", 146, 0);
    chk("pm_x", int'(cursor_x), 6);
    chk("pm_y", int'(cursor_y), 5);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    probe("erase_wins", 145, 0);

    // Random editing
    for (int i = 0; i < 1500; i++) rand_step(0);

    // Clear sweep with junk inputs and repeated clear_req
    goto_xy(0, 0);  step(0, 0, 0, 0, 1, 0, 0, 0);
    goto_xy(14, 14); step(0, 0, 0, 0, 1, 0, 0, 0);
    goto_xy(27, 27); step(0, 0, 0, 0, 1, 0, 0, 0);
    probe("pre_clr0", 0, 1);
    probe("pre_clr783", 783, 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    busy_cnt = 0;
    for (int k = 0; k < 2000 && busy; k++) begin
      busy_cnt++;
      rand_step(20);
    end
    chk("busy_len", busy_cnt, 784);
    chk("clear_x", int'(cursor_x), 27);
    sweep_all("post_clr");
    step(0, 0, 0, 0, 1, 0, 0, 0);
    probe("draw_again", 783, 1);

    // Random editing with occasional clears
    for (int i = 0; i < 4000; i++) rand_step(1);
    for (int k = 0; k < 2000 && m_busy; k++) idle();

    // Reset mid-sweep
    goto_xy(3, 9); step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 299; k++) rand_step(5);
    chk("mid_busy", int'(busy), 1);
    step(0, 0, 0, 0, 1, 0, 1, 1);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_x", int'(cursor_x), 14);
    chk("mrst_y", int'(cursor_y), 14);
    sweep_all("mrst");
    for (int i = 0; i < 200; i++) rand_step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
